// File: rtl/enc_out_serializer.sv
// enc_out_serializer: buffers AES ciphertext blocks in a small FIFO and streams
// each one as four 32-bit words, most-significant first, over valid/ready.
//
// Parameters:
//   DEPTH  block FIFO depth (power of two, >= 2)
//   AW     log2(DEPTH); derived, leave at default
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   ct_in       128-bit ciphertext block
//   ct_valid    one-cycle strobe per block
//   dout        current output word (0 when empty)
//   dout_valid  dout holds a valid word
//   dout_ready  consumer accepts dout this cycle
//   count       blocks held, including a partially sent one
//   overflow    sticky: a block was dropped while full
//   dout_last   final word of a block (only with ENC_OUT_LAST_EN defined)
// Optional feature macro: ENC_OUT_LAST_EN adds the dout_last port.
module enc_out_serializer #(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] ct_in,
    input  logic         ct_valid,
    output logic [31:0]  dout,
    output logic         dout_valid,
    input  logic         dout_ready,
    output logic [AW:0]  count,
    output logic         overflow
`ifdef ENC_OUT_LAST_EN
    ,
    output logic         dout_last
`endif
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [127:0] mem_q [DEPTH];

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic [1:0]    widx_q, widx_d;
    logic          ovf_q, ovf_d;

    logic full;
    logic xfer;
    logic pop;
    logic push;

    assign full = (count_q == FULL_CNT);
    assign xfer = dout_valid && dout_ready;
    assign pop  = xfer && (widx_q == 2'd3);
    // A final-word pop frees the head slot at the same edge, so a push is
    // still accepted when full in that case.
    assign push = ct_valid && (!full || pop);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        widx_d  = widx_q;
        ovf_d   = ovf_q;
        if (push) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + AW'(1);
        end
        if (xfer) begin
            widx_d = widx_q + 2'd1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        if (ct_valid && !push) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            widx_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            widx_q  <= widx_d;
            ovf_q   <= ovf_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wptr_q] <= ct_in;
        end
    end

    logic [127:0] head;
    logic [31:0]  word;

    assign head = mem_q[rptr_q];

    always_comb begin
        word = '0;
        unique case (widx_q)
            2'd0: word = head[127:96];
            2'd1: word = head[95:64];
            2'd2: word = head[63:32];
            2'd3: word = head[31:0];
            default: word = '0;
        endcase
    end

    assign dout_valid = (count_q != '0);
    assign dout       = dout_valid ? word : '0;
    assign count      = count_q;
    assign overflow   = ovf_q;

`ifdef ENC_OUT_LAST_EN
    assign dout_last = dout_valid && (widx_q == 2'd3);
`endif

endmodule

// File: tb/tb_enc_out_serializer.sv
// Scoreboard bench for enc_out_serializer: stimulus pushes expected words,
// a negedge monitor pops and compares them against the DUT.
module tb_enc_out_serializer;

    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] ct_in = '0;
    logic         ct_valid = 1'b0;
    logic [31:0]  dout;
    logic         dout_valid;
    logic         dout_ready = 1'b0;
    logic [2:0]   count;
    logic         overflow;
`ifdef ENC_OUT_LAST_EN
    logic         dout_last;
`endif

    always #5 clk = ~clk;

    enc_out_serializer #(.DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .ct_in(ct_in),
        .ct_valid(ct_valid),
        .dout(dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .count(count),
        .overflow(overflow)
`ifdef ENC_OUT_LAST_EN
        ,
        .dout_last(dout_last)
`endif
    );

    int checks = 0;
    int errors = 0;

    logic [31:0]  exp_q [$];
    logic         ovf_m = 1'b0;
    bit           mon_en = 1'b0;
    bit           pend_acc = 1'b0;
    bit           pend_drop = 1'b0;
    logic [127:0] pend_blk = '0;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Monitor: the queue holds exactly the words the DUT still owes.
    int msz;
    always @(negedge clk) begin
        if (mon_en) begin
            msz = exp_q.size();
            chk("dout_valid", 128'(dout_valid), 128'(msz != 0));
            chk("count", 128'(count), 128'((msz + 3) / 4));
            chk("overflow", 128'(overflow), 128'(ovf_m));
            if (msz != 0) chk("dout", 128'(dout), 128'(exp_q[0]));
            else          chk("dout_idle", 128'(dout), 128'(0));
`ifdef ENC_OUT_LAST_EN
            chk("dout_last", 128'(dout_last), 128'(msz % 4 == 1));
`endif
            if (msz != 0 && dout_ready) void'(exp_q.pop_front());
        end
    end

    task automatic apply_pending();
        if (pend_acc) begin
            for (int k = 0; k < 4; k++)
                exp_q.push_back(pend_blk[127-32*k -: 32]);
        end
        if (pend_drop) ovf_m = 1'b1;
        pend_acc  = 1'b0;
        pend_drop = 1'b0;
    endtask

    // One cycle: drive inputs, decide from the word queue whether the
    // block fits (room, or the head's last word leaves at this edge).
    task automatic step(input logic v, input logic [127:0] b,
                        input logic r);
        int  sz;
        bit  fin;
        @(posedge clk);
        #1;
        apply_pending();
        ct_valid   = v;
        ct_in      = b;
        dout_ready = r;
        sz  = exp_q.size();
        fin = r && (sz % 4 == 1);
        if (v) begin
            if (((sz + 3) / 4) < DEPTH || fin) begin
                pend_acc = 1'b1;
                pend_blk = b;
            end else begin
                pend_drop = 1'b1;
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        apply_pending();
        rst        = 1'b1;
        ct_valid   = 1'b0;
        dout_ready = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        ovf_m = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (exp_q.size() != 0 || pend_acc); i++)
            step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout actual=%0d words left required=0",
                     exp_q.size());
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    localparam logic [127:0] B1 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    localparam logic [127:0] B2 = 128'hf5d3d58503b9699de785895a96fdbaaf;
    localparam logic [127:0] B3 = 128'h43b1cd7f598ece23881b00e3ed030688;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;
        step(1'b0, '0, 1'b1);

        // T1 basic stream
        step(1'b1, B1, 1'b1);
        drain();

        // T2 back-to-back blocks, no bubble
        step(1'b1, B2, 1'b1);
        repeat (3) step(1'b0, '0, 1'b1);
        step(1'b1, B3, 1'b1);
        drain();

        // T3 backpressure pattern
        step(1'b1, B1, 1'b0);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        drain();

        // T4 full then overflow
        for (int i = 0; i < 5; i++) step(1'b1, rnd128(), 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b1, rnd128(), 1'b0);
        drain();
        do_reset();

        // T5 push together with final-word pop while full
        for (int i = 0; i < 4; i++) step(1'b1, rnd128(), 1'b0);
        repeat (3) step(1'b0, '0, 1'b1);
        step(1'b1, B3, 1'b1);
        drain();

        // T6 reset mid-block, then restart
        step(1'b1, B2, 1'b0);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        do_reset();
        step(1'b0, '0, 1'b1);
        step(1'b1, B1, 1'b1);
        drain();

        // Random traffic: light then heavy backpressure
        for (int i = 0; i < 800; i++) begin
            if (i == 500) do_reset();
            step(($urandom % 3) == 0, rnd128(),
                 (i < 400) ? (($urandom % 4) != 0) : (($urandom % 4) == 0));
        end
        drain();

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
